cpu_seq: RTL and testbench

Multi-cycle sequencer for the single-issue RV32 datapath: owns the program counter, drives the synchronous instruction ROM, latches the fetched instruction for the decoder and register file, and gates register-file writes so each instruction retires exactly once. It sits between `rom` and the core datapath (control decoder, ALU, register file) and replaces the free-running PC logic with an explicit fetch/decode/execute FSM. It supports run, single-step and halt at a programmable last PC.

---
 rtl/cpu_seq.sv | 93 +++++++++
 tb/tb_cpu_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// Multi-cycle fetch/decode/execute sequencer for the RV32 datapath.
// Owns the PC, drives the synchronous ROM, latches instructions and gates register-file writes.
module cpu_seq #(
    parameter int ADDR_WIDTH = 3,
    parameter int RET_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  step,
    input  logic [31:0]           last_pc,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_q,
    output logic [31:0]           instr,
    output logic [31:0]           pc,
    input  logic                  rf_we_in,
    output logic                  rf_we,
    output logic                  busy,
    output logic                  halted,
    output logic [RET_WIDTH-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_pc;
    logic [31:0]           r_instr;
    logic [RET_WIDTH-1:0]  r_retired;
    logic                  w_last;

    assign w_last = (r_pc == last_pc);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (run || step) w_next = S_FETCH;
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (w_last)   w_next = S_HALT;
                else if (run) w_next = S_FETCH;
                else          w_next = S_IDLE;
            end
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_instr   <= '0;
            r_retired <= '0;
        end else begin
            if (r_state == S_DECODE) begin
                r_instr <= rom_q;
            end
            if (r_state == S_EXEC) begin
                if (r_retired != '1) begin
                    r_retired <= r_retired + RET_WIDTH'(1);
                end
                // PC holds on the final instruction so halted reports last_pc.
                if (!w_last) begin
                    r_pc <= r_pc + 32'd1;
                end
            end
        end
    end

    assign rom_addr = r_pc[ADDR_WIDTH-1:0];
    assign pc       = r_pc;
    assign instr    = r_instr;
    assign retired  = r_retired;
    assign busy     = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
    assign halted   = (r_state == S_HALT);
    assign rf_we    = (r_state == S_EXEC) && rf_we_in;

endmodule

// File: tb/tb_cpu_seq.sv
// Self-checking bench for cpu_seq: instruction-level reference model with randomized
// ROM contents, write enables, run drops and ignored step/run noise.
module tb_cpu_seq;

    localparam int AW = 3;
    localparam int RW = 4;
    localparam int RET_MAX = (1 << RW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          run;
    logic          step;
    logic [31:0]   last_pc;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_q;
    logic [31:0]   instr;
    logic [31:0]   pc;
    logic          rf_we_in;
    logic          rf_we;
    logic          busy;
    logic          halted;
    logic [RW-1:0] retired;

    logic [31:0]   mem [8];

    int            n_checks = 0;
    int            n_fail   = 0;

    logic [31:0]   m_pc;
    logic [31:0]   m_instr;
    int            m_ret;
    bit            m_halted;
    bit            force_we;
    int            we_pulses;

    always #5 clk = ~clk;

    cpu_seq #(
        .ADDR_WIDTH (AW),
        .RET_WIDTH  (RW)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .step     (step),
        .last_pc  (last_pc),
        .rom_addr (rom_addr),
        .rom_q    (rom_q),
        .instr    (instr),
        .pc       (pc),
        .rf_we_in (rf_we_in),
        .rf_we    (rf_we),
        .busy     (busy),
        .halted   (halted),
        .retired  (retired)
    );

    // Synchronous instruction ROM: data valid one cycle after the address edge.
    always_ff @(posedge clk) rom_q <= mem[rom_addr];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat_inc(input int r);
        return (r >= RET_MAX) ? RET_MAX : r + 1;
    endfunction

    task automatic model_reset();
        m_pc     = 32'd0;
        m_instr  = 32'd0;
        m_ret    = 0;
        m_halted = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        run      = 1'b0;
        step     = 1'b0;
        rf_we_in = 1'b1;
        #1;
        model_reset();
        check("rst_pc",       pc,       0);
        check("rst_instr",    instr,    0);
        check("rst_retired",  retired,  0);
        check("rst_busy",     busy,     0);
        check("rst_halted",   halted,   0);
        check("rst_rf_we",    rf_we,    0);
        check("rst_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Entered at a negedge where the next rising edge starts FETCH; covers FETCH, DECODE, EXEC.
    task automatic do_instr(input int drop_at);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            rf_we_in = force_we ? 1'b1 : 1'($urandom_range(0, 1));
            step     = (c == 1);
            if (c == drop_at) run = 1'b0;
            #1;
            check("busy",     busy,     1);
            check("halted",   halted,   0);
            check("pc",       pc,       m_pc);
            check("rom_addr", rom_addr, m_pc % 8);
            check("retired",  retired,  m_ret);
            if (c == 2) begin
                m_instr = mem[m_pc % 8];
                check("instr_exec", instr, m_instr);
            end else begin
                check("instr_hold", instr, m_instr);
            end
            check("rf_we", rf_we, (c == 2) && rf_we_in);
            if (rf_we) we_pulses++;
        end
        m_ret = sat_inc(m_ret);
        if (m_pc == last_pc) m_halted = 1'b1;
        else                 m_pc = m_pc + 32'd1;
    endtask

    task automatic idle_cycles(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rf_we_in = 1'b1;
            if (noise) begin
                run  = 1'($urandom_range(0, 1));
                step = 1'($urandom_range(0, 1));
            end
            #1;
            check("idle_busy",    busy,    0);
            check("idle_halted",  halted,  m_halted);
            check("idle_pc",      pc,      m_pc);
            check("idle_retired", retired, m_ret);
            check("idle_rf_we",   rf_we,   0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst_n     = 1'b0;
        run       = 1'b0;
        step      = 1'b0;
        rf_we_in  = 1'b0;
        last_pc   = 32'd7;
        force_we  = 1'b0;
        we_pulses = 0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            w      = $urandom;
            mem[i] = {w[31:20], w[19:15], 3'b000, w[11:7], 7'h13};
        end

        // Full run of 8 instructions with rf_we_in tied high.
        apply_reset();
        last_pc   = 32'd7;
        force_we  = 1'b1;
        we_pulses = 0;
        run       = 1'b1;
        for (int i = 0; i < 8; i++) do_instr(-1);
        idle_cycles(1, 1'b0);
        check("full_halted",  halted,    1);
        check("full_pc",      pc,        7);
        check("full_retired", retired,   8);
        check("full_pulses",  we_pulses, 8);
        idle_cycles(3, 1'b1);
        force_we = 1'b0;

        // Single step; the extra step pulse in DECODE must be ignored.
        apply_reset();
        last_pc = 32'd100;
        step    = 1'b1;
        do_instr(-1);
        idle_cycles(4, 1'b0);
        check("step_pc", pc, 1);

        // Run dropped in DECODE of the third instruction.
        apply_reset();
        run = 1'b1;
        do_instr(-1);
        do_instr(-1);
        do_instr(1);
        idle_cycles(3, 1'b0);
        check("drop_pc",      pc,      3);
        check("drop_retired", retired, 3);

        // Reset asserted mid-EXEC drops rf_we without a clock edge.
        apply_reset();
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rf_we_in = 1'b1;
        #1;
        check("exec_rf_we", rf_we, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rf_we",   rf_we,   0);
        check("async_pc",      pc,      0);
        check("async_retired", retired, 0);
        check("async_busy",    busy,    0);
        model_reset();
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2, 1'b0);

        // Halt at zero with run/step noise afterwards.
        apply_reset();
        last_pc = 32'd0;
        step    = 1'b1;
        do_instr(-1);
        idle_cycles(6, 1'b1);

        // Randomized runs with ROM wrap, run drops, step restarts and counter saturation.
        for (int t = 0; t < 4; t++) begin
            apply_reset();
            last_pc = (t == 0) ? 32'd19 : 32'($urandom_range(5, 19));
            run     = 1'b1;
            for (int k = 0; k < 40; k++) begin
                do_instr(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1);
                if (m_halted) break;
                if (!run) begin
                    idle_cycles(int'($urandom_range(1, 3)), 1'b0);
                    if ($urandom_range(0, 1) == 1) run = 1'b1;
                    else                           step = 1'b1;
                end
            end
            idle_cycles(3, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
